// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // A single-bit operand still needs a 1-bit counter.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_sub_fs_cell.sv
// Combinational full-subtractor cell: d = x - y - bi, with borrow-out bo.
module fs_cell (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial W-bit subtractor: one fs_cell, LSB first, one bit per clock.
// Handshake: start is sampled only while busy = 0; done pulses for one cycle
// on the edge where busy falls, and diff/bout hold until the next completion.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] diff,
  output logic         bout
);

  localparam int CW = cnt_width(W);

  state_e         state_q;
  logic [W-1:0]   sa_q;
  logic [W-1:0]   sb_q;
  logic [W-1:0]   res_q;
  logic [W-1:0]   res_d;
  logic [W-1:0]   diff_q;
  logic           br_q;
  logic           bout_q;
  logic           done_q;
  logic [CW-1:0]  cnt_q;
  logic           cell_d;
  logic           cell_bo;
  logic           last_bit;

  fs_cell u_cell (
    .x  (sa_q[0]),
    .y  (sb_q[0]),
    .bi (br_q),
    .d  (cell_d),
    .bo (cell_bo)
  );

  // New bit enters at the MSB so the LSB-first result lands in place after W shifts.
  assign res_d    = (res_q >> 1) | (W'(cell_d) << (W - 1));
  assign last_bit = (cnt_q == CW'(W - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            sa_q    <= a;
            sb_q    <= b;
            br_q    <= bin;
            res_q   <= '0;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          sa_q  <= sa_q >> 1;
          sb_q  <= sb_q >> 1;
          br_q  <= cell_bo;
          res_q <= res_d;
          cnt_q <= cnt_q + CW'(1);
          if (last_bit) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
            diff_q  <= res_d;
            bout_q  <= cell_bo;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench for serial_sub (W = 4): directed vectors plus a full sweep.
module tb_serial_sub;

  localparam int W = 4;

  logic         clk   = 1'b0;
  logic         rst   = 1'b1;
  logic         start = 1'b0;
  logic         bin   = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;

  logic [W:0] exp_q[$];
  logic [W:0] mon_exp;
  int n_cmp  = 0;
  int n_bad  = 0;
  int n_done = 0;

  always #5 clk = ~clk;

  serial_sub #(.W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin,
                       input logic push, input logic [W:0] exp);
    a     = ta;
    b     = tb;
    bin   = tbin;
    start = 1'b1;
    if (push) exp_q.push_back(exp);
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (busy && n < limit) begin
      n++;
      step();
    end
    if (busy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_idle: busy still %0d after %0d cycles", busy, limit);
    end
  endtask

  // Monitor: every done cycle pops one expected {bout, diff}.
  always @(negedge clk) begin
    if (!rst && done) begin
      n_done++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got diff %0d bout %0d with empty queue", diff, bout);
      end else begin
        mon_exp = exp_q.pop_front();
        check("result", {27'd0, bout, diff}, {27'd0, mon_exp});
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int done_snap;
    logic [W:0] m;

    // Reset state
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_diff", diff, 0);
    check("rst_bout", bout, 0);
    step();
    step();
    rst = 1'b0;
    step();

    // Basic: 5 - 3 = 2, busy for exactly W cycles, done right after
    issue(4'd5, 4'd3, 1'b0, 1'b1, 5'd2);
    n = 0;
    while (busy && n < 20) begin
      n++;
      step();
    end
    check("busy_cycles", n, 4);
    check("done_at_latency", done, 1);

    // Underflow cases
    issue(4'd3, 4'd5, 1'b0, 1'b1, 5'd30);
    wait_idle(10);
    issue(4'd0, 4'd0, 1'b1, 1'b1, 5'd31);
    wait_idle(10);
    issue(4'd15, 4'd15, 1'b1, 1'b1, 5'd31);
    wait_idle(10);
    step();

    // Exhaustive with start held high: next busy must follow each done cycle
    start = 1'b1;
    for (int i = 0; i < 512; i++) begin
      a   = i[8:5];
      b   = i[4:1];
      bin = i[0];
      m   = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
      exp_q.push_back(m);
      step();
      check("b2b_busy", busy, 1);
      wait_idle(10);
    end
    start = 1'b0;
    step();
    step();

    // Busy-ignore: second start during RUN must not restart or queue
    done_snap = n_done;
    issue(4'd9, 4'd2, 1'b0, 1'b1, 5'd7);
    step();
    a     = 4'd1;
    b     = 4'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_idle(10);
    step();
    step();
    step();
    check("ignore_one_done", n_done - done_snap, 1);

    // Reset mid-operation clears outputs asynchronously, no done follows
    issue(4'd12, 4'd4, 1'b0, 1'b0, '0);
    step();
    #3;
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_diff", diff, 0);
    check("midrst_bout", bout, 0);
    done_snap = n_done;
    step();
    rst = 1'b0;
    repeat (8) step();
    check("midrst_no_done", n_done - done_snap, 0);
    issue(4'd6, 4'd6, 1'b0, 1'b1, 5'd0);
    wait_idle(10);
    step();

    // Output hold: result stays stable while idle
    issue(4'd10, 4'd7, 1'b0, 1'b1, 5'd3);
    wait_idle(10);
    step();
    repeat (20) begin
      check("hold_diff", diff, 3);
      check("hold_bout", bout, 0);
      check("hold_done", done, 0);
      step();
    end

    repeat (3) step();
    check("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
